// File: rtl/alu_result_stage.sv
// alu_result_stage: execute-to-writeback stage sitting directly behind the ALU.
//
// Captures the ALU result, branch decision and flags together with instruction metadata into a
// two-entry skid buffer that drains to writeback over a valid/ready handshake. A taken branch or
// jump produces a one-cycle redirect pulse. Cycles where an instruction waits on a mul/div result
// (alu_valid low) are counted in a saturating stall counter.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   flush                synchronous flush: empties the buffer and drops this cycle's input
//   in_valid/in_ready    upstream handshake (in_ready depends only on registered state, flush, rst)
//   alu_*                ALU result, result-valid, branch-taken and flags
//   in_is_branch/jump    instruction class
//   in_target/rd/pc      redirect target, destination register, instruction PC
//   out_valid/out_ready  writeback handshake for the head entry
//   out_result/rd/we/exc/pc  head entry fields
//   redirect_valid/pc    one-cycle redirect pulse and target
//   stall_cnt            saturating mul/div stall cycle count

package alu_result_stage_pkg;
    typedef struct packed {
        logic invalid_op;
        logic overflow;
        logic carry;
        logic negative;
        logic zero;
    } alu_flags_t;
endpackage

module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_valid,
    input  logic                  alu_branch,
    input  alu_flags_t            alu_flags,
    input  logic                  in_is_branch,
    input  logic                  in_is_jump,
    input  logic [WIDTH-1:0]      in_target,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [WIDTH-1:0]      in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_we,
    output logic                  out_exc,
    output logic [WIDTH-1:0]      out_pc,
    output logic                  redirect_valid,
    output logic [WIDTH-1:0]      redirect_pc,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0]      result;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  exc;
        logic [WIDTH-1:0]      pc;
    } entry_t;

    logic [1:0]       count_q, count_d;
    entry_t           ent0_q, ent0_d;   // head
    entry_t           ent1_q, ent1_d;   // second (tail when full)
    entry_t           new_ent;
    logic             redirect_valid_q, redirect_valid_d;
    logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic accept;
    logic pop;
    logic stall;
    logic take_redirect;

    // No path from out_ready: a full buffer refuses input even when it is popped this cycle.
    assign in_ready = (count_q != 2'd2) && !flush && !rst;
    assign accept   = in_valid && alu_valid && in_ready;
    assign stall    = in_valid && !alu_valid && in_ready;
    assign pop      = out_valid && out_ready;

    assign take_redirect = accept && !alu_flags.invalid_op &&
                           (in_is_jump || (in_is_branch && alu_branch));

    always_comb begin
        new_ent.result = alu_result;
        new_ent.rd     = in_rd;
        new_ent.we     = (in_rd != '0) && !alu_flags.invalid_op && !in_is_branch;
        new_ent.exc    = alu_flags.invalid_op;
        new_ent.pc     = in_pc;
    end

    always_comb begin
        count_d          = count_q;
        ent0_d           = ent0_q;
        ent1_d           = ent1_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        stall_cnt_d      = stall_cnt_q;

        if (!flush) begin
            // accept already excludes count==2, so accept+pop only happens with one entry held
            case ({accept, pop})
                2'b11: ent0_d = new_ent;
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_d = new_ent;
                    end else begin
                        ent1_d = new_ent;
                    end
                    count_d = count_q + 2'd1;
                end
                default: ;
            endcase

            redirect_valid_d = take_redirect;
            if (take_redirect) begin
                redirect_pc_d = in_target;
            end
        end else begin
            count_d = 2'd0;
        end

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q          <= 2'd0;
            ent0_q           <= '0;
            ent1_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            stall_cnt_q      <= '0;
        end else begin
            count_q          <= count_d;
            ent0_q           <= ent0_d;
            ent1_q           <= ent1_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign out_valid      = (count_q != 2'd0);
    assign out_result     = ent0_q.result;
    assign out_rd         = ent0_q.rd;
    assign out_we         = ent0_q.we;
    assign out_exc        = ent0_q.exc;
    assign out_pc         = ent0_q.pc;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    localparam int unsigned WIDTH      = 64;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      alu_result;
    logic                  alu_valid;
    logic                  alu_branch;
    alu_flags_t            alu_flags;
    logic                  in_is_branch;
    logic                  in_is_jump;
    logic [WIDTH-1:0]      in_target;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [WIDTH-1:0]      in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_result;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_we;
    logic                  out_exc;
    logic [WIDTH-1:0]      out_pc;
    logic                  redirect_valid;
    logic [WIDTH-1:0]      redirect_pc;
    logic [CNT_W-1:0]      stall_cnt;

    alu_result_stage #(
        .WIDTH(WIDTH),
        .REG_ADDR_W(REG_ADDR_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_valid(alu_valid), .alu_branch(alu_branch),
        .alu_flags(alu_flags), .in_is_branch(in_is_branch), .in_is_jump(in_is_jump),
        .in_target(in_target), .in_rd(in_rd), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we), .out_exc(out_exc), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of expected writeback entries plus redirect / counter state.
    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
        logic [63:0] pc;
    } m_ent_t;

    m_ent_t      mq[$];
    logic        m_red;
    logic [63:0] m_rpc;
    int unsigned m_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_result", out_result, mq[0].res);
            chk("out_rd", out_rd, mq[0].rd);
            chk("out_we", out_we, mq[0].we);
            chk("out_exc", out_exc, mq[0].exc);
            chk("out_pc", out_pc, mq[0].pc);
        end
        chk("redirect_valid", redirect_valid, m_red);
        if (m_red) chk("redirect_pc", redirect_pc, m_rpc);
        chk("stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic model_reset();
        mq.delete();
        m_red = 1'b0;
        m_rpc = '0;
        m_cnt = 0;
    endtask

    // One clock with the currently driven inputs; model advances from the same inputs.
    task automatic cycle();
        logic   rdy, acc, pp, take, stl;
        m_ent_t e;
        logic [63:0] tgt;
        rdy = (mq.size() != 2) && !flush;
        #1;
        chk("in_ready", in_ready, rdy);
        acc    = in_valid && alu_valid && rdy;
        stl    = in_valid && !alu_valid && rdy;
        pp     = (mq.size() != 0) && out_ready;
        e.res  = alu_result;
        e.rd   = in_rd;
        e.exc  = alu_flags.invalid_op;
        e.we   = (in_rd != 0) && !alu_flags.invalid_op && !in_is_branch;
        e.pc   = in_pc;
        take   = acc && !alu_flags.invalid_op && (in_is_jump || (in_is_branch && alu_branch));
        tgt    = in_target;
        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
            m_red = 1'b0;
        end else begin
            if (pp) mq.delete(0);
            if (acc) mq.push_back(e);
            m_red = take;
            if (take) m_rpc = tgt;
        end
        if (stl && m_cnt != CNT_MAX) m_cnt++;
        check_outputs();
    endtask

    task automatic set_idle();
        flush        = 1'b0;
        in_valid     = 1'b0;
        alu_valid    = 1'b1;
        alu_branch   = 1'b0;
        alu_flags    = '0;
        in_is_branch = 1'b0;
        in_is_jump   = 1'b0;
        in_target    = '0;
        in_rd        = '0;
        in_pc        = '0;
        alu_result   = '0;
        out_ready    = 1'b1;
    endtask

    task automatic instr(input logic [4:0] rd, input logic [63:0] res, input logic [63:0] pc);
        in_valid     = 1'b1;
        alu_valid    = 1'b1;
        alu_branch   = 1'b0;
        alu_flags    = '0;
        in_is_branch = 1'b0;
        in_is_jump   = 1'b0;
        in_rd        = rd;
        alu_result   = res;
        in_pc        = pc;
    endtask

    task automatic randomize_inputs();
        flush          = ($urandom_range(0, 15) == 0);
        in_valid       = ($urandom_range(0, 3) != 0);
        alu_valid      = ($urandom_range(0, 7) != 0);
        alu_branch     = 1'($urandom_range(0, 1));
        alu_flags      = '0;
        alu_flags.invalid_op = ($urandom_range(0, 7) == 0);
        alu_flags.zero = 1'($urandom_range(0, 1));
        in_is_branch   = ($urandom_range(0, 3) == 0);
        in_is_jump     = !in_is_branch && ($urandom_range(0, 5) == 0);
        in_target      = {$urandom(), $urandom()};
        in_rd          = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        in_pc          = {$urandom(), $urandom()};
        alu_result     = {$urandom(), $urandom()};
        out_ready      = ($urandom_range(0, 1) == 1);
    endtask

    initial begin
        set_idle();
        model_reset();
        rst = 1'b1;
        #3;
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst redirect_valid", redirect_valid, 0);
        chk("rst stall_cnt", stall_cnt, 0);
        chk("rst out_result", out_result, 0);
        chk("rst redirect_pc", redirect_pc, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single ADD, rd=5
        instr(5'd5, 64'h2A, 64'h100);
        cycle();
        chk("add out_valid", out_valid, 1);
        chk("add out_rd", out_rd, 5);
        chk("add out_we", out_we, 1);
        chk("add out_result", out_result, 64'h2A);
        set_idle();
        cycle();

        // Backpressure: three back-to-back offers with out_ready low
        out_ready = 1'b0;
        instr(5'd1, 64'h11, 64'h200);
        cycle();
        instr(5'd2, 64'h22, 64'h204);
        cycle();
        instr(5'd3, 64'h33, 64'h208);
        #1;
        chk("full in_ready", in_ready, 0);
        cycle();
        chk("full head", out_result, 64'h11);
        out_ready = 1'b1;
        cycle();
        chk("pop1 head", out_result, 64'h22);
        cycle();
        chk("pop2 head", out_result, 64'h33);
        set_idle();
        cycle();
        chk("drained", out_valid, 0);

        // BEQ taken
        instr(5'd7, 64'h0, 64'h300);
        in_is_branch = 1'b1;
        alu_branch   = 1'b1;
        in_target    = 64'h1000;
        cycle();
        chk("beq redirect_valid", redirect_valid, 1);
        chk("beq redirect_pc", redirect_pc, 64'h1000);
        chk("beq out_we", out_we, 0);
        set_idle();
        cycle();
        chk("beq pulse end", redirect_valid, 0);

        // invalid_op on a jump: exception, no write, no redirect
        instr(5'd3, 64'h44, 64'h400);
        in_is_jump           = 1'b1;
        in_target            = 64'h2000;
        alu_flags.invalid_op = 1'b1;
        cycle();
        chk("inv out_exc", out_exc, 1);
        chk("inv out_we", out_we, 0);
        chk("inv redirect", redirect_valid, 0);
        set_idle();
        cycle();

        // flush with two entries held plus a valid input
        out_ready = 1'b0;
        instr(5'd9, 64'h55, 64'h500);
        cycle();
        cycle();
        flush = 1'b1;
        #1;
        chk("flush in_ready", in_ready, 0);
        cycle();
        chk("flush out_valid", out_valid, 0);
        set_idle();
        #1;
        chk("flush count0", in_ready, 1);

        // rd=0 write
        instr(5'd0, 64'h66, 64'h600);
        cycle();
        chk("rd0 out_we", out_we, 0);
        set_idle();
        cycle();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            randomize_inputs();
            cycle();
        end

        // asynchronous reset mid-operation
        set_idle();
        out_ready = 1'b0;
        instr(5'd4, 64'h77, 64'h700);
        cycle();
        cycle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst out_valid", out_valid, 0);
        chk("arst in_ready", in_ready, 0);
        chk("arst stall_cnt", stall_cnt, 0);
        rst = 1'b0;
        set_idle();

        // DIV stalling 33 cycles, then accepted; then saturate
        instr(5'd8, 64'h88, 64'h800);
        alu_valid = 1'b0;
        for (int i = 0; i < 33; i++) cycle();
        chk("div stall 33", stall_cnt, 33);
        alu_valid = 1'b1;
        cycle();
        chk("div accepted", out_valid, 1);
        chk("div result", out_result, 64'h88);
        alu_valid = 1'b0;
        for (int i = 0; i < 40; i++) cycle();
        chk("stall saturated", stall_cnt, CNT_MAX);
        cycle();
        chk("stall held", stall_cnt, CNT_MAX);
        set_idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
